lenet_crop_scheduler: RTL and testbench
=======================================

// Module: lenet_crop_scheduler
// PURPOSE
//  Shares the single frame-buffer read port between VGA scan-out and the LeNet input path.
//  VGA always wins. On a start pulse the block walks the centred lenet_size x lenet_size
//  crop, reading one sample per cell in cycles the VGA leaves idle, and streams
//  4-bit pixels to the LeNet core over a valid/ready handshake.
//  It sits between the VGA timing block, the frame buffer (1-cycle read latency) and LeNet.
// PARAMETERS
//  widthlength   8    horizontal cell size in frame pixels (even, >=2)
//  heightlength  8    vertical cell size in frame pixels (even, >=2)
//  lenet_size    28   crop edge in cells; stream length N = lenet_size^2 (784)
//  hRez          640  frame width in pixels
//  vRez          480  frame height in pixels
// PORTS
//  clk25        in   1   pixel clock; all logic on posedge
//  rst_n        in   1   asynchronous active-low reset
//  vga_addr     in   19  VGA scan-out read address
//  vga_req      in   1   1 = VGA consumes the read port this cycle
//  frame_pixel  in   4   frame-buffer read data; valid 1 cycle after fb_addr
//  fb_addr      out  19  frame-buffer read address (combinational mux)
//  lenet_start  in   1   1-cycle pulse: capture one crop
//  lenet_pixel  out  4   crop sample, raster order by cell
//  lenet_valid  out  1   lenet_pixel valid; held until accepted
//  lenet_ready  in   1   LeNet accepts when lenet_valid & lenet_ready
//  lenet_last   out  1   qualifies the final sample (index N-1)
//  busy         out  1   1 whenever state != IDLE
//  done         out  1   1-cycle pulse in the cycle after the last sample is accepted
// BEHAVIOUR
//  Reset: state IDLE, cell row/col = 0, lenet_pixel = 0, lenet_valid/lenet_last/busy/done = 0.
//  Geometry: X0 = hRez/2 - widthlength*lenet_size/2, Y0 = vRez/2 - heightlength*lenet_size/2.
//   Sample(r,c) address = (Y0 + r*heightlength + heightlength/2)*hRez
//                         + X0 + c*widthlength + widthlength/2.
//   Defaults give first = 84692 (x=212,y=132), last = 223148 (x=428,y=348).
//   Computed incrementally (row-base register + column offset); no multipliers.
//  Port mux: fb_addr = vga_addr unless state == ISSUE and vga_req == 0, then crop address.
//   VGA is never stalled or delayed.
//  FSM:
//   IDLE    : lenet_start -> ISSUE; row=col=0. lenet_start in any other state is ignored.
//   ISSUE   : if vga_req=0, crop address drives fb_addr -> CAPTURE; else stay (retry next cycle).
//   CAPTURE : frame_pixel registered into lenet_pixel; lenet_valid<=1;
//             lenet_last<=(row==col==lenet_size-1) -> HOLD.
//   HOLD    : on accept: lenet_valid<=0, lenet_last<=0; if last -> DONE; else advance cell -> ISSUE.
//             lenet_pixel/lenet_last are stable while lenet_valid & !lenet_ready.
//   DONE    : done=1 for one cycle -> IDLE.
//  Cell advance: col+1; at col==lenet_size-1, col=0, row+1, row base += heightlength*hRez.
//  Throughput: at most one sample per 3 cycles; no samples are skipped or duplicated.
//  Reset mid-capture: immediate return to reset values; a partial crop is abandoned and done is not pulsed.
//  The crop spans any frame boundaries crossed; frame alignment is the caller's job.
// TESTING
//  T1 vga_req=0, ready=1, start -> 784 samples in order; first fb_addr 84692, last 223148;
//     lenet_last only on #784; done one cycle later; busy low after.
//  T2 vga_req=1 for 50 cycles during ISSUE -> fb_addr==vga_addr throughout; crop read
//     issues on the first vga_req=0 cycle with the correct address.
//  T3 lenet_ready=0 for 10 cycles with valid high -> lenet_pixel/lenet_last stable;
//     no new crop read issued; stream resumes intact.
//  T4 lenet_start pulsed while busy -> ignored; still exactly 784 samples, one done pulse.
//  T5 rst_n low at sample 300 -> all outputs 0, IDLE; a new start restarts at address 84692.
//  T6 full VGA timing (640-active/800-total) with random lenet_ready -> frame data
//     matches a memory model; every VGA read is unperturbed.

Source files
------------

// File: rtl/lenet_crop_scheduler.sv
// lenet_crop_scheduler
//
// Shares the single frame-buffer read port between VGA scan-out and the LeNet
// input path. VGA always has priority; the crop walker only borrows the port in
// cycles where vga_req is low. On lenet_start the block walks the centred
// lenet_size x lenet_size grid of cells, reads the centre sample of each cell
// and streams it to LeNet over a valid/ready handshake.
//
// Ports
//   clk25        in   pixel clock, all logic on posedge
//   rst_n        in   asynchronous active-low reset
//   vga_addr     in   VGA scan-out read address
//   vga_req      in   VGA owns the read port this cycle
//   frame_pixel  in   frame-buffer read data, valid one cycle after fb_addr
//   fb_addr      out  frame-buffer read address (combinational mux)
//   lenet_start  in   one-cycle pulse, capture one crop (ignored while busy)
//   lenet_pixel  out  crop sample, raster order by cell
//   lenet_valid  out  lenet_pixel valid, held until accepted
//   lenet_ready  in   LeNet accepts when lenet_valid & lenet_ready
//   lenet_last   out  marks the final sample of the crop
//   busy         out  high whenever the walker is not idle
//   done         out  one-cycle pulse after the last sample is accepted
//
// State table
//   state   | meaning
//   IDLE    | waiting for lenet_start
//   ISSUE   | crop read pending; issued on the first cycle VGA leaves idle
//   CAPTURE | read data arrives; register it into lenet_pixel
//   HOLD    | lenet_valid high, waiting for lenet_ready
//   DONE    | done pulse, then back to IDLE

module lenet_crop_scheduler #(
    parameter int widthlength  = 8,
    parameter int heightlength = 8,
    parameter int lenet_size   = 28,
    parameter int hRez         = 640,
    parameter int vRez         = 480
) (
    input  logic        clk25,
    input  logic        rst_n,
    input  logic [18:0] vga_addr,
    input  logic        vga_req,
    input  logic [3:0]  frame_pixel,
    output logic [18:0] fb_addr,
    input  logic        lenet_start,
    output logic [3:0]  lenet_pixel,
    output logic        lenet_valid,
    input  logic        lenet_ready,
    output logic        lenet_last,
    output logic        busy,
    output logic        done
);

    localparam int CW = (lenet_size > 1) ? $clog2(lenet_size) : 1;
    localparam int X0 = hRez / 2 - (widthlength * lenet_size) / 2;
    localparam int Y0 = vRez / 2 - (heightlength * lenet_size) / 2;

    // Address of the centre sample of cell (0,0); every other cell is reached
    // by adding row and column strides, so no multiplier is needed.
    localparam logic [18:0] FIRST_ADDR =
        19'((Y0 + heightlength / 2) * hRez + X0 + widthlength / 2);
    localparam logic [18:0] ROW_STEP  = 19'(heightlength * hRez);
    localparam logic [18:0] COL_STEP  = 19'(widthlength);
    localparam logic [CW-1:0] LAST_CELL = CW'(lenet_size - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        HOLD,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic [18:0]   row_base;
    logic [18:0]   col_off;
    logic [18:0]   crop_addr;
    logic          crop_rd;
    logic          crop_load;
    logic          cell_adv;
    logic          at_last_cell;

    assign crop_addr    = row_base + col_off;
    assign at_last_cell = (row == LAST_CELL) && (col == LAST_CELL);

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        crop_load = 1'b0;
        crop_rd   = 1'b0;
        cell_adv  = 1'b0;
        fb_addr   = vga_addr;
        busy      = (state != IDLE);
        done      = (state == DONE);

        case (state)
            IDLE: begin
                if (lenet_start) begin
                    crop_load = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // VGA is never delayed: the crop read only takes a free cycle.
                if (!vga_req) begin
                    crop_rd   = 1'b1;
                    fb_addr   = crop_addr;
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                // lenet_valid is always high in HOLD, so ready alone means accept.
                if (lenet_ready) begin
                    if (lenet_last) begin
                        state_nxt = DONE;
                    end else begin
                        cell_adv  = 1'b1;
                        state_nxt = ISSUE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Cell walker: column offset and row base are stepped, never multiplied.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            row      <= '0;
            col      <= '0;
            row_base <= FIRST_ADDR;
            col_off  <= '0;
        end else if (crop_load) begin
            row      <= '0;
            col      <= '0;
            row_base <= FIRST_ADDR;
            col_off  <= '0;
        end else if (cell_adv) begin
            if (col == LAST_CELL) begin
                col      <= '0;
                col_off  <= '0;
                row      <= row + CW'(1);
                row_base <= row_base + ROW_STEP;
            end else begin
                col      <= col + CW'(1);
                col_off  <= col_off + COL_STEP;
            end
        end
    end

    // Output stage: lenet_pixel/lenet_last only change in CAPTURE, so they are
    // stable for the whole HOLD interval while LeNet back-pressures.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            lenet_pixel <= '0;
            lenet_valid <= 1'b0;
            lenet_last  <= 1'b0;
        end else if (state == CAPTURE) begin
            lenet_pixel <= frame_pixel;
            lenet_valid <= 1'b1;
            lenet_last  <= at_last_cell;
        end else if ((state == HOLD) && lenet_ready) begin
            lenet_valid <= 1'b0;
            lenet_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lenet_crop_scheduler.sv
// Self-checking bench for lenet_crop_scheduler: a frame-buffer memory model,
// a cell-index reference model for the crop addresses and samples, and one
// compare process that checks every cycle on the falling edge.

module tb_lenet_crop_scheduler;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int L  = 28;
    localparam int HR = 640;
    localparam int VR = 480;
    localparam int N  = L * L;
    localparam logic [18:0] NO_VGA = 19'h7FFFF;

    logic        clk25 = 1'b0;
    logic        rst_n = 1'b1;
    logic [18:0] vga_addr;
    logic        vga_req;
    logic [3:0]  frame_pixel = 4'd0;
    logic [18:0] fb_addr;
    logic        lenet_start;
    logic [3:0]  lenet_pixel;
    logic        lenet_valid;
    logic        lenet_ready;
    logic        lenet_last;
    logic        busy;
    logic        done;

    lenet_crop_scheduler #(
        .widthlength (W),
        .heightlength(H),
        .lenet_size  (L),
        .hRez        (HR),
        .vRez        (VR)
    ) dut (
        .clk25      (clk25),
        .rst_n      (rst_n),
        .vga_addr   (vga_addr),
        .vga_req    (vga_req),
        .frame_pixel(frame_pixel),
        .fb_addr    (fb_addr),
        .lenet_start(lenet_start),
        .lenet_pixel(lenet_pixel),
        .lenet_valid(lenet_valid),
        .lenet_ready(lenet_ready),
        .lenet_last (lenet_last),
        .busy       (busy),
        .done       (done)
    );

    always #20 clk25 = ~clk25;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: frame address of the centre of cell k in raster order.
    function automatic int exp_addr(input int k);
        int r;
        int c;
        int x0;
        int y0;
        r  = k / L;
        c  = k % L;
        x0 = HR / 2 - (W * L) / 2;
        y0 = VR / 2 - (H * L) / 2;
        return (y0 + r * H + H / 2) * HR + x0 + c * W + W / 2;
    endfunction

    // Frame-buffer contents as a function of address.
    function automatic logic [3:0] fpix(input logic [18:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ {1'b0, a[18:16]};
    endfunction

    // Frame buffer with one-cycle read latency.
    always @(posedge clk25) frame_pixel <= fpix(fb_addr);

    // Reference-model state
    int   acc_idx     = 0;
    int   issue_idx   = 0;
    bit   outstanding = 1'b0;
    bit   hold_prev   = 1'b0;
    bit   done_exp    = 1'b0;
    bit   done_prev   = 1'b0;
    logic [3:0] held_pix  = 4'd0;
    logic       held_last = 1'b0;
    int   done_count  = 0;
    int   run_samples = 0;
    int   first_addr  = -1;
    int   last_addr   = -1;

    always @(negedge clk25) begin
        if (!rst_n) begin
            check("rst_outputs_zero",
                  longint'({lenet_pixel, lenet_valid, lenet_last, busy, done}), 0);
            acc_idx     = 0;
            issue_idx   = 0;
            outstanding = 1'b0;
            hold_prev   = 1'b0;
            done_exp    = 1'b0;
            done_prev   = 1'b0;
            first_addr  = -1;
            last_addr   = -1;
            run_samples = 0;
        end else begin
            if (vga_req) begin
                check("vga_passthru", fb_addr, vga_addr);
            end else if (fb_addr != vga_addr) begin
                check("crop_addr", fb_addr, exp_addr(issue_idx));
                check("one_in_flight", outstanding, 0);
                if (issue_idx == 0) first_addr = int'(fb_addr);
                if (issue_idx == N - 1) last_addr = int'(fb_addr);
                issue_idx++;
                outstanding = 1'b1;
            end

            if (hold_prev) begin
                check("hold_valid", lenet_valid, 1);
                check("hold_pixel", lenet_pixel, held_pix);
                check("hold_last", lenet_last, held_last);
            end

            if (lenet_valid) check("busy_when_valid", busy, 1);
            if (done_prev) check("idle_after_done", busy, 0);

            check("done_pulse", done, done_exp);
            done_prev = done;
            done_exp  = 1'b0;
            if (done) begin
                done_count++;
                run_samples = acc_idx;
                acc_idx     = 0;
                issue_idx   = 0;
            end

            if (lenet_valid && lenet_ready) begin
                check("pixel", lenet_pixel, fpix(19'(exp_addr(acc_idx))));
                check("last_flag", lenet_last, (acc_idx == N - 1) ? 1 : 0);
                acc_idx++;
                outstanding = 1'b0;
                done_exp    = (acc_idx == N);
            end

            hold_prev = lenet_valid && !lenet_ready;
            held_pix  = lenet_pixel;
            held_last = lenet_last;
        end
    end

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    task automatic pulse_start();
        lenet_start = 1'b1;
        tick();
        lenet_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        int n;
        d0 = done_count;
        n  = 0;
        while (done_count == d0 && n < budget) begin
            tick();
            n++;
        end
        check({name, "_done_seen"}, done_count - d0, 1);
        tick();
        tick();
        check({name, "_busy_low"}, busy, 0);
    endtask

    initial begin
        int n;
        int d0;
        int h;
        int v;

        vga_req     = 1'b0;
        vga_addr    = NO_VGA;
        lenet_start = 1'b0;
        lenet_ready = 1'b1;

        #5 rst_n = 1'b0;
        repeat (3) @(posedge clk25);
        #1 rst_n = 1'b1;
        tick();
        check("reset_busy", busy, 0);
        check("reset_valid", lenet_valid, 0);

        // Hand-computed geometry pins for the reference model.
        check("model_first", exp_addr(0), 84692);
        check("model_col1", exp_addr(1), 84700);
        check("model_row1", exp_addr(L), 89812);
        check("model_last", exp_addr(N - 1), 223148);

        // T1: free port, always ready.
        pulse_start();
        wait_done("t1", 4000);
        check("t1_samples", run_samples, 784);
        check("t1_first_addr", first_addr, 84692);
        check("t1_last_addr", last_addr, 223148);

        // T2: VGA holds the port for 50 cycles during ISSUE.
        vga_req  = 1'b1;
        vga_addr = 19'd1000;
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            vga_addr = 19'(2000 + i * 7);
            tick();
        end
        vga_req  = 1'b0;
        vga_addr = NO_VGA;
        @(negedge clk25);
        check("t2_first_free_addr", fb_addr, 84692);
        tick();
        wait_done("t2", 4000);
        check("t2_samples", run_samples, 784);

        // T3: back-pressure for 10 cycles while valid is high.
        pulse_start();
        n = 0;
        while (acc_idx < 5 && n < 100) begin
            tick();
            n++;
        end
        n = 0;
        while (!lenet_valid && n < 20) begin
            tick();
            n++;
        end
        check("t3_valid_seen", lenet_valid, 1);
        lenet_ready = 1'b0;
        repeat (10) tick();
        check("t3_valid_stalled", lenet_valid, 1);
        check("t3_acc_frozen", acc_idx, 5);
        lenet_ready = 1'b1;
        wait_done("t3", 4000);
        check("t3_samples", run_samples, 784);

        // T4: start pulses while busy are ignored.
        d0 = done_count;
        pulse_start();
        repeat (100) tick();
        pulse_start();
        repeat (201) tick();
        pulse_start();
        wait_done("t4", 4000);
        check("t4_samples", run_samples, 784);
        repeat (20) tick();
        check("t4_single_done", done_count - d0, 1);

        // T5: reset at sample 300 abandons the crop; restart begins at cell 0.
        pulse_start();
        n = 0;
        while (acc_idx < 300 && n < 2000) begin
            tick();
            n++;
        end
        check("t5_reached_300", acc_idx, 300);
        d0 = done_count;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", lenet_valid, 0);
        check("t5_async_busy", busy, 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("t5_no_done", done_count, d0);
        check("t5_idle", busy, 0);
        pulse_start();
        wait_done("t5", 4000);
        check("t5_restart_addr", first_addr, 84692);
        check("t5_samples", run_samples, 784);

        // T6: 640-active / 800-total line timing with random ready.
        d0 = done_count;
        h  = 0;
        v  = 0;
        n  = 0;
        while (done_count == d0 && n < 60000) begin
            vga_req     = (h < 640);
            vga_addr    = vga_req ? 19'(v * HR + h) : NO_VGA;
            lenet_ready = 1'($urandom_range(0, 1));
            lenet_start = (n == 5);
            tick();
            n++;
            h++;
            if (h == 800) begin
                h = 0;
                v = (v + 1) % VR;
            end
        end
        lenet_start = 1'b0;
        lenet_ready = 1'b1;
        vga_req     = 1'b0;
        vga_addr    = NO_VGA;
        check("t6_done_seen", done_count - d0, 1);
        tick();
        tick();
        check("t6_samples", run_samples, 784);
        check("t6_busy_low", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
